// File: rtl/softmax_pkg.sv
// Shared constants and the result-reader state encoding for the softmax datapath.
package softmax_pkg;

    localparam int SM_DEPTH  = 32;  // words per softmax row
    localparam int SM_OUT_W  = 16;  // Q0.16 unsigned output word
    localparam int SM_ADDR_W = 5;   // $clog2(SM_DEPTH)
    localparam int SM_SUM_W  = 21;  // SM_OUT_W + SM_ADDR_W, holds 32 * 65535 without overflow

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/softmax_result_reader_if.sv
// Control, BRAM port-B and output-stream signals of the softmax result reader.
// Stream handshake: a word transfers on a rising clock edge when o_valid and
// i_ready are both high; while o_valid is high and i_ready is low, o_data,
// o_index and o_last hold their values, and o_valid never drops before the
// transfer completes.
interface softmax_result_reader_if
    import softmax_pkg::*;
#(
    parameter int DATA_W = SM_OUT_W,
    parameter int ADDR_W = SM_ADDR_W
);
    logic                     i_start;
    logic                     o_busy;
    logic                     o_bram_en;
    logic [ADDR_W-1:0]        o_bram_addr;
    logic [DATA_W-1:0]        i_bram_dout;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_W-1:0]        o_data;
    logic [ADDR_W-1:0]        o_index;
    logic                     o_last;
    logic [DATA_W+ADDR_W-1:0] o_sum;
    logic                     o_done;

    modport master (
        input  i_start, i_bram_dout, i_ready,
        output o_busy, o_bram_en, o_bram_addr, o_valid, o_data, o_index,
               o_last, o_sum, o_done
    );

    modport slave (
        output i_start, i_bram_dout, i_ready,
        input  o_busy, o_bram_en, o_bram_addr, o_valid, o_data, o_index,
               o_last, o_sum, o_done
    );
endinterface

// File: rtl/softmax_rd_fifo.sv
// Small synchronous FIFO buffering {data, index} words returned by the BRAM.
module softmax_rd_fifo #(
    parameter  int WIDTH = 21,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/softmax_result_reader.sv
// Drains one softmax result row from BRAM port B and streams it out with
// index, last flag and a running sum. Reads are credit-limited so that every
// issued read has a guaranteed FIFO slot, hence backpressure never drops data.
module softmax_result_reader
    import softmax_pkg::*;
#(
    parameter int DEPTH      = SM_DEPTH,
    parameter int DATA_W     = SM_OUT_W,
    parameter int ADDR_W     = SM_ADDR_W,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    softmax_result_reader_if.master bus,
    output rd_state_t dbg_state
);
    localparam int SUM_W   = DATA_W + ADDR_W;
    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    rd_state_t         state;
    rd_state_t         next_state;
    logic [ADDR_W-1:0] issue_cnt;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              issue;
    logic              accept_start;
    logic              handshake;
    logic              tap;
    logic [SUM_W-1:0]  sum_q;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [ADDR_W-1:0]     pipe_idx [RD_LATENCY];

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign accept_start = (state == RD_IDLE) && bus.i_start;
    assign handshake    = bus.o_valid && bus.i_ready;
    assign tap          = pipe_vld[RD_LATENCY-1];
    assign occupancy    = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok    = (occupancy < (CNT_W+1)'(FIFO_DEPTH)) && !fifo_full;
    assign fifo_din     = {bus.i_bram_dout, pipe_idx[RD_LATENCY-1]};
    assign dbg_state    = state;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RD_IDLE;
        else          state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            RD_IDLE:  if (bus.i_start) next_state = RD_ISSUE;
            RD_ISSUE: if (issue && (issue_cnt == ADDR_W'(DEPTH - 1))) next_state = RD_DRAIN;
            RD_DRAIN: if (handshake && bus.o_last) next_state = RD_DONE;
            RD_DONE:  next_state = RD_IDLE;
            default:  next_state = RD_IDLE;
        endcase
    end

    // State-decoded outputs and read issue.
    always_comb begin
        issue           = (state == RD_ISSUE) && credit_ok;
        bus.o_busy      = (state != RD_IDLE);
        bus.o_done      = (state == RD_DONE);
        bus.o_bram_en   = issue;
        bus.o_bram_addr = issue ? issue_cnt : '0;
    end

    // Issue address counter and count of reads still inside the BRAM pipe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issue_cnt <= '0;
            inflight  <= '0;
        end else begin
            if (accept_start) issue_cnt <= '0;
            else if (issue)   issue_cnt <= issue_cnt + 1'b1;
            unique case ({issue, tap})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Latency pipe: tracks which cycles carry valid BRAM data and their index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_idx[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_idx[0] <= issue_cnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

    // Running sum of handed-off words; cleared when a new row starts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          sum_q <= '0;
        else if (accept_start) sum_q <= '0;
        else if (handshake)    sum_q <= sum_q + {{ADDR_W{1'b0}}, bus.o_data};
    end

    softmax_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (tap),
        .pop   (handshake),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stream outputs are forced to zero while the FIFO is empty.
    always_comb begin
        bus.o_valid = !fifo_empty;
        bus.o_data  = bus.o_valid ? fifo_dout[ENTRY_W-1 -: DATA_W] : '0;
        bus.o_index = bus.o_valid ? fifo_dout[ADDR_W-1:0] : '0;
        bus.o_last  = bus.o_valid && (fifo_dout[ADDR_W-1:0] == ADDR_W'(DEPTH - 1));
        bus.o_sum   = sum_q;
    end
endmodule

// File: tb/tb_softmax_result_reader.sv
// Directed bench for softmax_result_reader: main instance at RD_LATENCY=2,
// plus RD_LATENCY=1 and RD_LATENCY=3 instances checked on a shared row.
module tb_softmax_result_reader;
    import softmax_pkg::*;

    localparam int DEPTH  = 32;
    localparam int LAT    = 2;
    localparam int FIFO_D = LAT + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [DEPTH];
    logic [15:0] exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    softmax_result_reader_if #(.DATA_W(16), .ADDR_W(5)) bus ();
    rd_state_t dbg_state;

    softmax_result_reader #(.RD_LATENCY(LAT)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // BRAM port-B model with LAT cycles from address sample to data.
    logic [15:0] m_pipe [LAT];
    always @(posedge clk) begin
        if (bus.o_bram_en) m_pipe[0] <= mem[bus.o_bram_addr];
        for (int k = 1; k < LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign bus.i_bram_dout = m_pipe[LAT-1];

    // Latency-variant instances, always ready, sharing one start pulse.
    logic        x_start;
    logic        x_valid [2];
    logic [15:0] x_data  [2];
    logic [4:0]  x_index [2];
    logic        x_last  [2];
    logic [20:0] x_sum   [2];
    logic        x_done  [2];

    for (genvar g = 0; g < 2; g++) begin : lat_g
        localparam int L = (g == 0) ? 1 : 3;
        softmax_result_reader_if #(.DATA_W(16), .ADDR_W(5)) xbus ();
        rd_state_t   xstate;
        logic [15:0] xp [L];
        softmax_result_reader #(.RD_LATENCY(L)) xdut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .bus       (xbus),
            .dbg_state (xstate)
        );
        assign xbus.i_start = x_start;
        assign xbus.i_ready = 1'b1;
        always @(posedge clk) begin
            if (xbus.o_bram_en) xp[0] <= mem[xbus.o_bram_addr];
            for (int k = 1; k < L; k++) xp[k] <= xp[k-1];
        end
        assign xbus.i_bram_dout = xp[L-1];
        assign x_valid[g] = xbus.o_valid;
        assign x_data[g]  = xbus.o_data;
        assign x_index[g] = xbus.o_index;
        assign x_last[g]  = xbus.o_last;
        assign x_sum[g]   = xbus.o_sum;
        assign x_done[g]  = xbus.o_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
            $error("%s differs", tag);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(bus.o_busy), 0);
        chk({tag, "_en"},    32'(bus.o_bram_en), 0);
        chk({tag, "_addr"},  32'(bus.o_bram_addr), 0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_data"},  32'(bus.o_data), 0);
        chk({tag, "_index"}, 32'(bus.o_index), 0);
        chk({tag, "_last"},  32'(bus.o_last), 0);
        chk({tag, "_sum"},   32'(bus.o_sum), 0);
        chk({tag, "_done"},  32'(bus.o_done), 0);
    endtask

    // mode 0: ready=1; mode 1: random ready; mode 2: ready=0 for 20 cycles.
    // Entered and left about 2 time units after a rising edge.
    task automatic run_row(input int mode, input int restart_beat, input int abort_beat,
                           input bit start_in_done, output int edges, output int beats);
        int          last_edge;
        int          issued;
        int          done_cnt;
        bit          restarted;
        bit          hold_v;
        logic [15:0] hold_data;
        logic [4:0]  hold_idx;
        logic [15:0] exp_d;
        logic [20:0] model_sum;
        edges = 0; beats = 0; last_edge = -10; issued = 0; done_cnt = 0;
        restarted = 0; hold_v = 0; hold_data = '0; hold_idx = '0; model_sum = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
        bus.i_start = 1'b1;
        bus.i_ready = (mode == 0);
        for (int cyc = 0; cyc < 600 && done_cnt == 0; cyc++) begin
            @(posedge clk);
            edges++;
            #1;
            bus.i_start = 1'b0;
            if (restart_beat >= 0 && beats == restart_beat && !restarted) begin
                bus.i_start = 1'b1;
                restarted = 1;
            end
            case (mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'($urandom_range(0, 1));
                default: bus.i_ready = (edges > 20);
            endcase
            #1;
            if (edges == 1) begin
                chk("sum_cleared", 32'(bus.o_sum), 0);
                chk("busy_after_start", 32'(bus.o_busy), 1);
                chk("first_addr", 32'(bus.o_bram_addr), 0);
            end
            if (restarted && done_cnt == 0 && bus.i_start)
                chk("busy_on_restart", 32'(bus.o_busy), 1);
            if (hold_v) begin
                chk("stall_valid", 32'(bus.o_valid), 1);
                chk("stall_data", 32'(bus.o_data), 32'(hold_data));
                chk("stall_index", 32'(bus.o_index), 32'(hold_idx));
            end
            if (mode == 2 && edges <= 20 && bus.o_bram_en) issued++;
            if (mode == 2 && edges == 20) begin
                chk("stall_issued", issued, FIFO_D);
                chk("stall_en_low", 32'(bus.o_bram_en), 0);
            end
            if (bus.o_done) begin
                done_cnt++;
                chk("done_after_last", edges, last_edge + 1);
                chk("sum_model", 32'(bus.o_sum), 32'(model_sum));
                if (start_in_done) bus.i_start = 1'b1;
            end else if (bus.o_valid && bus.i_ready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk("beat_data", 32'(bus.o_data), 32'(exp_d));
                chk("beat_index", 32'(bus.o_index), beats);
                chk("beat_last", 32'(bus.o_last), 32'(beats == DEPTH - 1));
                model_sum += {5'd0, exp_d};
                if (bus.o_last) last_edge = edges;
                beats++;
                if (abort_beat >= 0 && beats == abort_beat) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset_outputs("abort");
                    return;
                end
            end
            hold_v    = bus.o_valid && !bus.i_ready;
            hold_data = bus.o_data;
            hold_idx  = bus.o_index;
        end
        chk("done_seen", done_cnt, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            #1;
            if (bus.o_done) done_cnt++;
            chk("idle_after_done", 32'(bus.o_busy), 0);
        end
        chk("beats", beats, DEPTH);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int edges;
        int beats;
        int xi [2];
        int xe [2];

        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;
        x_start     = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'd2048;

        // Clock/reset
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        chk("reset_state", 32'(dbg_state), 32'(RD_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Uniform row, ready held high.
        run_row(0, -1, -1, 1'b0, edges, beats);
        chk("uniform_latency", edges, 36);
        chk("uniform_sum", 32'(bus.o_sum), 65536);

        // Ramp row, random backpressure.
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 64);
        run_row(1, -1, -1, 1'b0, edges, beats);
        chk("ramp_random_sum", 32'(bus.o_sum), 31744);

        // Long initial stall limits issued reads.
        run_row(2, -1, -1, 1'b0, edges, beats);
        chk("ramp_stall_sum", 32'(bus.o_sum), 31744);

        // Start at beat 10 and in the DONE cycle are both ignored; rerun repeats.
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'd2048;
        run_row(0, 10, -1, 1'b1, edges, beats);
        chk("restart_latency", edges, 36);
        chk("restart_sum", 32'(bus.o_sum), 65536);
        run_row(0, -1, -1, 1'b0, edges, beats);
        chk("rerun_latency", edges, 36);
        chk("rerun_sum", 32'(bus.o_sum), 65536);

        // Reset after 15 beats, then a clean row.
        run_row(0, -1, 15, 1'b0, edges, beats);
        chk("abort_beats", beats, 15);
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            chk("abort_no_done", 32'(bus.o_done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk_reset_outputs("post_abort");
        run_row(0, -1, -1, 1'b0, edges, beats);
        chk("post_abort_sum", 32'(bus.o_sum), 65536);

        // Latency variants on an irregular row: sum = 2000*496 + 7*32 = 992224.
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i * 2000 + 7);
        xi[0] = 0; xi[1] = 0; xe[0] = -1; xe[1] = -1;
        x_start = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            x_start = 1'b0;
            #1;
            for (int g = 0; g < 2; g++) begin
                if (x_valid[g]) begin
                    chk("lat_data", 32'(x_data[g]), 32'(mem[xi[g] % DEPTH]));
                    chk("lat_index", 32'(x_index[g]), xi[g]);
                    chk("lat_last", 32'(x_last[g]), 32'(xi[g] == DEPTH - 1));
                    xi[g]++;
                end
                if (x_done[g] && xe[g] < 0) xe[g] = e;
            end
        end
        chk("lat1_beats", xi[0], DEPTH);
        chk("lat3_beats", xi[1], DEPTH);
        chk("lat1_latency", xe[0], 35);
        chk("lat3_latency", xe[1], 37);
        chk("lat1_sum", 32'(x_sum[0]), 992224);
        chk("lat3_sum", 32'(x_sum[1]), 992224);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
